// File: rtl/nx_fifo_param_pkg.sv
// Shared constants and helpers for the nx_fifo family.
package nx_fifo_pkg;

    localparam int NX_RD_SHOWAHEAD = 0;
    localparam int NX_RD_REG       = 1;

    // Occupancy counts need one extra bit so that "full" (== DEPTH) is representable.
    function automatic int nx_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Pointers wrap by natural binary overflow, so DEPTH must be a power of two.
    function automatic bit nx_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/nx_fifo_param_ctrl.sv
// Pointer, occupancy and flag control for nx_fifo_param (no data path).
module nx_fifo_ctrl_param
    import nx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = nx_cnt_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wen,
    input  logic                       ren,
    input  logic [CNT_W-1:0]           af_thresh,
    input  logic [CNT_W-1:0]           ae_thresh,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [CNT_W-1:0]           used_slots,
    output logic [CNT_W-1:0]           free_slots,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       ovf_sticky,
    output logic                       udf_sticky,
    output logic                       wr_acc,
    output logic                       rd_acc,
    output logic [$clog2(DEPTH)-1:0]   wptr,
    output logic [$clog2(DEPTH)-1:0]   rptr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] used_q, used_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             ovfs_q, ovfs_d, udfs_q, udfs_d;

    // Flags come straight from the registered count, so they lag the access by one cycle.
    assign empty        = (used_q == '0);
    assign full         = (used_q == DEPTH_C);
    assign almost_full  = (used_q >= af_thresh);
    assign almost_empty = (used_q <= ae_thresh);
    assign used_slots   = used_q;
    assign free_slots   = DEPTH_C - used_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign ovf_sticky   = ovfs_q;
    assign udf_sticky   = udfs_q;
    assign wptr         = wptr_q;
    assign rptr         = rptr_q;

    // Acceptance uses this cycle's flags only; clear overrides any access.
    assign wr_acc = wen & ~full & ~clear;
    assign rd_acc = ren & ~empty & ~clear;

    // Next-state for pointers, occupancy and error flags.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        used_d = used_q;
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
        ovfs_d = ovfs_q;
        udfs_d = udfs_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            used_d = '0;
            ovfs_d = 1'b0;
            udfs_d = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + AW'(1);
            if (rd_acc) rptr_d = rptr_q + AW'(1);
            if (wr_acc && !rd_acc)      used_d = used_q + CNT_W'(1);
            else if (rd_acc && !wr_acc) used_d = used_q - CNT_W'(1);
            ovf_d  = wen & full;
            udf_d  = ren & empty;
            ovfs_d = ovfs_q | ovf_d;
            udfs_d = udfs_q | udf_d;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            used_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            ovfs_q <= 1'b0;
            udfs_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            used_q <= used_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            ovfs_q <= ovfs_d;
            udfs_q <= udfs_d;
        end
    end

endmodule

// File: rtl/nx_fifo_param.sv
// Parametrised single-clock FIFO: storage array plus show-ahead or registered read port.
module nx_fifo_param
    import nx_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int RDATA_REG = 0,
    parameter int CNT_W     = nx_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    input  logic [CNT_W-1:0] af_thresh,
    input  logic [CNT_W-1:0] ae_thresh,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] used_slots,
    output logic [CNT_W-1:0] free_slots,
    output logic             overflow,
    output logic             underflow,
    output logic             ovf_sticky,
    output logic             udf_sticky
);

    localparam int AW = $clog2(DEPTH);

    if (!nx_depth_ok(DEPTH)) begin : g_depth_chk
        $error("nx_fifo_param: DEPTH must be a power of two >= 2");
    end

    logic             wr_acc, rd_acc;
    logic [AW-1:0]    wptr, rptr;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    nx_fifo_ctrl_param #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .wen          (wen),
        .ren          (ren),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .used_slots   (used_slots),
        .free_slots   (free_slots),
        .overflow     (overflow),
        .underflow    (underflow),
        .ovf_sticky   (ovf_sticky),
        .udf_sticky   (udf_sticky),
        .wr_acc       (wr_acc),
        .rd_acc       (rd_acc),
        .wptr         (wptr),
        .rptr         (rptr)
    );

    // Storage is deliberately left unreset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr] <= wdata;
    end

    assign head     = mem_q[rptr];
    assign rdata_d  = rd_acc ? head : rdata_q;
    assign rvalid_d = rd_acc;

    // Registered read port; rdata holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Mode is a constant select: show-ahead presents the head word, zero when empty.
    assign rdata  = (RDATA_REG == NX_RD_REG) ? rdata_q  : (empty ? '0 : head);
    assign rvalid = (RDATA_REG == NX_RD_REG) ? rvalid_q : ~empty;

endmodule
